ehgu_clkdiv_ratio_meter: RTL and testbench



---
 rtl/ehgu_clkdiv_ratio_meter.sv | 178 +++++++++++++++++
 tb/tb_ehgu_clkdiv_ratio_meter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehgu_clkdiv_ratio_meter.sv
// Recovers the average sig_in period over 2^FRAC_W periods as int_div.frac_div, plus per-window min/max.
// Rise seen SYNC_STAGES+1 cycles after sig_in; result one cycle after the closing rise; no backpressure, results overwrite.
module ehgu_clkdiv_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int FRAC_W      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  int_div,
    output logic [FRAC_W-1:0] frac_div,
    output logic [CNT_W-1:0]  period_min,
    output logic [CNT_W-1:0]  period_max,
    output logic              timeout,
    output logic              busy
);
    localparam int ACC_W = CNT_W + FRAC_W;
    localparam logic [CNT_W-1:0] PCNT_MAX  = '1;
    localparam logic [CNT_W-1:0] PCNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [FRAC_W:0]  ECNT_LAST = {1'b0, {FRAC_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sync_out;
    logic sig_d;
    logic rise;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_out = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clkin) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clkin) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sync_out;
        end
    end

    assign rise = sync_out & ~sig_d;

    // Free-running period counter; saturates so a stuck input times out only once.
    logic [CNT_W-1:0] pcnt;
    logic             pcnt_expire;

    always_ff @(posedge clkin) begin
        if (rst) begin
            pcnt <= '0;
        end else if (rise) begin
            pcnt <= CNT_W'(1);
        end else if (pcnt != PCNT_MAX) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign pcnt_expire = ~rise && (pcnt == PCNT_PRE);

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (rise) state_nxt = MEASURE;
                MEASURE: if (pcnt_expire) state_nxt = SYNC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic win_open;
    logic win_rise;
    logic tmo_fire;

    always_comb begin
        busy     = 1'b0;
        win_open = 1'b0;
        win_rise = 1'b0;
        tmo_fire = 1'b0;
        case (state)
            SYNC: begin
                win_open = en & rise;
                tmo_fire = en & pcnt_expire;
            end
            MEASURE: begin
                busy     = 1'b1;
                win_rise = en & rise;
                tmo_fire = en & pcnt_expire;
            end
            default: ;
        endcase
    end

    logic [ACC_W-1:0]  acc;
    logic [FRAC_W:0]   ecnt;
    logic [CNT_W-1:0]  win_min;
    logic [CNT_W-1:0]  win_max;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  min_upd;
    logic [CNT_W-1:0]  max_upd;
    logic              win_close;

    assign acc_sum   = acc + {{FRAC_W{1'b0}}, pcnt};
    assign min_upd   = (pcnt < win_min) ? pcnt : win_min;
    assign max_upd   = (pcnt > win_max) ? pcnt : win_max;
    assign win_close = win_rise && (ecnt == ECNT_LAST);

    // The closing rise publishes the window and opens the next one in the same cycle.
    always_ff @(posedge clkin) begin
        if (rst) begin
            acc        <= '0;
            ecnt       <= '0;
            win_min    <= '0;
            win_max    <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            int_div    <= '0;
            frac_div   <= '0;
            period_min <= '0;
            period_max <= '0;
        end else begin
            meas_valid <= win_close;
            timeout    <= tmo_fire;
            if (win_open || win_close) begin
                acc     <= '0;
                ecnt    <= '0;
                win_min <= PCNT_MAX;
                win_max <= '0;
            end else if (win_rise) begin
                acc     <= acc_sum;
                ecnt    <= ecnt + 1'b1;
                win_min <= min_upd;
                win_max <= max_upd;
            end
            if (win_close) begin
                int_div    <= acc_sum[ACC_W-1:FRAC_W];
                frac_div   <= acc_sum[FRAC_W-1:0];
                period_min <= min_upd;
                period_max <= max_upd;
            end
        end
    end

endmodule

// File: tb/tb_ehgu_clkdiv_ratio_meter.sv
// Directed bench for ehgu_clkdiv_ratio_meter: four instances with SYNC_STAGES 0..3 share the stimulus.
module tb_ehgu_clkdiv_ratio_meter;
    localparam int CW   = 8;
    localparam int FW   = 2;
    localparam int NS   = 4;
    localparam int MAIN = 2;

    typedef struct {
        int i;
        int f;
        int mn;
        int mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sig_in;

    logic          mv  [NS];
    logic [CW-1:0] idv [NS];
    logic [FW-1:0] fdv [NS];
    logic [CW-1:0] pmn [NS];
    logic [CW-1:0] pmx [NS];
    logic          tmo [NS];
    logic          bsy [NS];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : g_dut
        ehgu_clkdiv_ratio_meter #(
            .CNT_W(CW),
            .FRAC_W(FW),
            .SYNC_STAGES(g)
        ) dut (
            .clkin(clk),
            .rst(rst),
            .en(en),
            .sig_in(sig_in),
            .meas_valid(mv[g]),
            .int_div(idv[g]),
            .frac_div(fdv[g]),
            .period_min(pmn[g]),
            .period_max(pmx[g]),
            .timeout(tmo[g]),
            .busy(bsy[g])
        );
    end

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   mv_cnt = 0;
    int   tmo_cnt = 0;
    int   tmo_first = -1;
    int   last_mv = -1;
    int   first_mv [NS];
    exp_t sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: inputs were set at the previous negedge, outputs sampled at this one.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        for (int s = 0; s < NS; s++) begin
            if (mv[s] === 1'b1 && first_mv[s] < 0) first_mv[s] = cyc_n;
        end
        if (tmo[MAIN] === 1'b1) begin
            tmo_cnt++;
            if (tmo_first < 0) tmo_first = cyc_n;
        end
        if (mv[MAIN] === 1'b1) begin
            mv_cnt++;
            last_mv = cyc_n;
            chk("meas_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("int_div", 32'(idv[MAIN]), e.i);
                chk("frac_div", 32'(fdv[MAIN]), e.f);
                chk("period_min", 32'(pmn[MAIN]), e.mn);
                chk("period_max", 32'(pmx[MAIN]), e.mx);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive_period(input int p);
        for (int k = 0; k < p; k++) begin
            sig_in = (k < p / 2);
            step();
        end
    endtask

    task automatic drive_rises(input int p0, input int p1, input int p2, input int p3, input int n);
        int pat [4];
        pat = '{p0, p1, p2, p3};
        for (int k = 0; k < n; k++) drive_period(pat[k % 4]);
    endtask

    task automatic push(input int i, input int f, input int mn, input int mx, input int n);
        exp_t e;
        e.i  = i;
        e.f  = f;
        e.mn = mn;
        e.mx = mx;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    task automatic clear_marks();
        for (int s = 0; s < NS; s++) first_mv[s] = -1;
        mv_cnt    = 0;
        tmo_cnt   = 0;
        tmo_first = -1;
    endtask

    task automatic reenable();
        en = 1'b0;
        idle(3);
        en = 1'b1;
        idle(3);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mv"}, 32'(mv[MAIN]), 0);
        chk({tag, "_int"}, 32'(idv[MAIN]), 0);
        chk({tag, "_frac"}, 32'(fdv[MAIN]), 0);
        chk({tag, "_min"}, 32'(pmn[MAIN]), 0);
        chk({tag, "_max"}, 32'(pmx[MAIN]), 0);
        chk({tag, "_tmo"}, 32'(tmo[MAIN]), 0);
        chk({tag, "_busy"}, 32'(bsy[MAIN]), 0);
    endtask

    initial begin
        int c;
        int cr;
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        clear_marks();
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // Divider pattern for 3.25: periods 3,3,3,4; also the SYNC_STAGES sweep.
        en = 1'b1;
        idle(3);
        chk("sync_busy", 32'(bsy[MAIN]), 0);
        push(3, 1, 3, 4, 3);
        clear_marks();
        c = cyc_n;
        drive_rises(3, 3, 3, 4, 13);
        cr = c + 39;
        idle(5);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("first_lat_s%0d", s), first_mv[s], c + 14 + s);
            if (s != MAIN) begin
                chk($sformatf("sweep_int_s%0d", s), 32'(idv[s]), 3);
                chk($sformatf("sweep_frac_s%0d", s), 32'(fdv[s]), 1);
            end
        end
        chk("lock_count", mv_cnt, 3);
        chk("lock_last", last_mv, c + 40 + MAIN);

        // Input stuck low after the last rise.
        tmo_cnt   = 0;
        tmo_first = -1;
        idle(cr + MAIN + 555 - cyc_n);
        chk("stuck_tmo_count", tmo_cnt, 1);
        chk("stuck_tmo_time", tmo_first, cr + MAIN + 255);
        chk("stuck_hold_int", 32'(idv[MAIN]), 3);
        chk("stuck_hold_frac", 32'(fdv[MAIN]), 1);
        chk("stuck_hold_min", 32'(pmn[MAIN]), 3);
        chk("stuck_hold_max", 32'(pmx[MAIN]), 4);
        chk("stuck_busy", 32'(bsy[MAIN]), 0);

        push(3, 1, 3, 4, 1);
        clear_marks();
        c = cyc_n;
        drive_rises(3, 3, 3, 4, 5);
        idle(5);
        chk("restart_lat", first_mv[MAIN], c + 14 + MAIN);
        chk("restart_count", mv_cnt, 1);

        // Constant period 8.
        reenable();
        push(8, 0, 8, 8, 2);
        clear_marks();
        c = cyc_n;
        drive_rises(8, 8, 8, 8, 9);
        idle(5);
        chk("p8_first", first_mv[MAIN], c + 1 + MAIN + 32);
        chk("p8_spacing", last_mv - first_mv[MAIN], 32);
        chk("p8_count", mv_cnt, 2);

        // Minimum period 2.
        reenable();
        push(2, 0, 2, 2, 2);
        clear_marks();
        drive_rises(2, 2, 2, 2, 9);
        idle(5);
        chk("p2_count", mv_cnt, 2);

        // 5.75: periods 5,6,6,6.
        reenable();
        push(5, 3, 5, 6, 2);
        clear_marks();
        drive_rises(5, 6, 6, 6, 9);
        idle(5);
        chk("frac_count", mv_cnt, 2);

        // en dropped after two rises.
        reenable();
        clear_marks();
        drive_rises(8, 8, 8, 8, 2);
        idle(3);
        en = 1'b0;
        idle(3);
        chk("endrop_busy", 32'(bsy[MAIN]), 0);
        idle(20);
        chk("endrop_mv", mv_cnt, 0);
        chk("endrop_tmo", tmo_cnt, 0);
        chk("endrop_int", 32'(idv[MAIN]), 5);
        chk("endrop_frac", 32'(fdv[MAIN]), 3);
        chk("endrop_min", 32'(pmn[MAIN]), 5);
        chk("endrop_max", 32'(pmx[MAIN]), 6);
        en = 1'b1;
        idle(3);
        push(6, 0, 6, 6, 1);
        clear_marks();
        c = cyc_n;
        drive_rises(6, 6, 6, 6, 5);
        idle(5);
        chk("enback_lat", first_mv[MAIN], c + 1 + MAIN + 24);
        chk("enback_count", mv_cnt, 1);

        // One-cycle rst in the middle of a window.
        reenable();
        clear_marks();
        drive_rises(7, 7, 7, 7, 2);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("midrst");
        idle(3);
        push(7, 0, 7, 7, 1);
        clear_marks();
        c = cyc_n;
        drive_rises(7, 7, 7, 7, 5);
        idle(5);
        chk("postrst_lat", first_mv[MAIN], c + 1 + MAIN + 28);
        chk("postrst_count", mv_cnt, 1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
